uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Byte-buffering front end for the UART transmitter. Accepts bytes from the host side into an internal FIFO and drives the transmitter's `data` / `Tx_WR` / `Tx_EN` inputs, launching one byte at a time and pacing on the transmitter's `busy` output. It sits directly upstream of the UART top and owns all transmit-side flow control.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; power of two, at least 2.
- `AW`, 4: log2(`DEPTH`).
- `BUSY_TIMEOUT`, 8: maximum cycles to wait for `busy` to rise after a launch.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits launching new bytes.
- `flush`  in  1  synchronous clear of FIFO contents; the byte in flight is unaffected.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `fifo_count`  out  AW+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky; set when a push is rejected.
- `tx_error`  out  1  sticky; set when a `busy` timeout occurs.
- `bytes_sent`  out  16  count of completed bytes; wraps from 0xFFFF to 0.
- `data`  out  8  byte presented to the transmitter.
- `Tx_WR`  out  1  one-cycle write strobe to the transmitter.
- `Tx_EN`  out  1  transmitter enable.
- `busy`  in  1  transmitter busy.

## Operation
- **Reset (`reset`=0):** `data`=0x00, `Tx_WR`=0, `Tx_EN`=0, `full`=0, `empty`=1, `fifo_count`=0, `overflow`=0, `tx_error`=0, `bytes_sent`=0, FSM in IDLE, FIFO pointers at 0. Reset takes effect immediately, including mid-byte. Deasserting `reset` clears nothing in the UART itself.
- **FIFO:** circular buffer with `AW`-bit read/write pointers that wrap from `DEPTH`-1 to 0. `full` and `empty` are decoded from the registered `fifo_count`.
- **Push rules:**
  - A push is accepted when `wr_en`=1 and `full`=0.
  - A push with `full`=1 is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
- **Flush:** `flush`=1 resets both pointers and `fifo_count` to 0. A flush overrides a simultaneous push, and that push is discarded without setting `overflow`.
- **FSM states:**
  - **IDLE:** if `enable`=1, `empty`=0, `busy`=0 and `flush`=0, pop the head byte into `data` and go to LOAD.
  - **LOAD:** `Tx_WR`=1 for this single cycle; go to WAIT_BUSY and clear the timeout counter.
  - **WAIT_BUSY:**
    - If `busy`=1, go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`, set `tx_error` and go to IDLE. The byte is counted as lost and `bytes_sent` does not increment.
  - **WAIT_DONE:** when `busy`=0, increment `bytes_sent` and go to IDLE.
- **`Tx_EN`:** registered; equals `enable` OR (state ≠ IDLE). Dropping `enable` mid-byte lets the current byte complete, then `Tx_EN` falls.
- **`data`:** holds its value until the next pop.
- **Sticky flags:** `overflow` and `tx_error` clear only on reset.

## Timing
- Push sampled at edge k → `fifo_count`/`empty` update after edge k.
- Earliest launch when idle:
  - Pop and `data` update at edge k+1.
  - `Tx_WR` is high from after edge k+1 until after edge k+2, exactly one cycle.
- The transmitter samples `data` on the edge that ends the `Tx_WR` cycle. `busy` is expected within `BUSY_TIMEOUT` cycles of that edge.
- Back-to-back bytes: a new launch can pop on the first edge after `busy` is seen low in WAIT_DONE and the FSM returns to IDLE. Minimum gap between `Tx_WR` pulses is 3 cycles plus the `busy` high time.
- `busy` already high in IDLE: no launch until it drops.
- `fifo_count` is never negative and never exceeds `DEPTH`. A pop is impossible while `empty`=1.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles → every output at its reset value; release → outputs unchanged until a push.
- **Single byte:** `enable`=1, push 0xAA; model `busy` high 2 cycles after `Tx_WR` for 20 cycles → one `Tx_WR` pulse with `data`=0xAA, `bytes_sent`=1, `empty`=1, `Tx_EN` stays 1.
- **FIFO fill and drain:** `enable`=0, push 17 bytes 0x00..0x10 → `full`=1, `fifo_count`=16, `overflow`=1, byte 0x10 lost. Then `enable`=1 → 16 `Tx_WR` pulses carrying 0x00..0x0F in order, `bytes_sent`=16, `empty`=1.
- **Busy timeout:** push 0x55 with `busy` tied 0 → `Tx_WR` pulse, `tx_error`=1 after `BUSY_TIMEOUT` cycles, `bytes_sent`=0. The next byte 0xCC still launches.
- **Flush during transmission:** queue 0x01, 0x02, 0x03; assert `flush` while byte 0x01 is in WAIT_DONE → 0x01 completes, `bytes_sent`=1, no further `Tx_WR`, `fifo_count`=0.
- **Reset mid-byte and simultaneous push/pop:** async `reset`=0 in WAIT_DONE → outputs at reset values immediately. Separately, push coincident with a pop at `fifo_count`=5 → `fifo_count` stays 5.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter: one byte per Tx_WR strobe,
// paced on the transmitter's busy handshake with a bounded wait for busy to rise.
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic          tx_error,
    output logic [15:0]   bytes_sent,
    output logic [7:0]    data,
    output logic          Tx_WR,
    output logic          Tx_EN,
    input  logic          busy
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_CNT = TW'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [AW:0]    r_count;
    logic [TW-1:0]  r_tcnt, w_tcnt_nxt;
    logic [7:0]     r_data;
    logic           r_tx_wr, r_tx_en, r_overflow, r_tx_error;
    logic [15:0]    r_sent;
    logic           w_pop, w_push, w_timeout, w_done;

    assign full       = (r_count == FULL_CNT);
    assign empty      = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_error   = r_tx_error;
    assign bytes_sent = r_sent;
    assign data       = r_data;
    assign Tx_WR      = r_tx_wr;
    assign Tx_EN      = r_tx_en;

    // Flush wins over a same-cycle push and discards it silently.
    assign w_push = wr_en && !full && !flush;

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !empty && !busy && !flush) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_tcnt_nxt  = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                    if (w_tcnt_nxt == TMO_CNT) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_tx_wr <= 1'b0;
            r_tx_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_tx_wr <= w_pop;
            r_tx_en <= enable || (w_state_nxt != S_IDLE);
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_data  <= 8'h00;
        end else begin
            if (w_pop) r_data <= r_mem[r_rptr];
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_tx_error <= 1'b0;
            r_sent     <= '0;
        end else begin
            if (wr_en && full && !flush) r_overflow <= 1'b1;
            if (w_timeout)               r_tx_error <= 1'b1;
            if (w_done)                  r_sent     <= r_sent + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: transaction-level model (byte queue + in-flight byte
// timeline) compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BT    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0, flush = 1'b0, wr_en = 1'b0, busy = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, overflow, tx_error, Tx_WR, Tx_EN;
    logic [AW:0]   fifo_count;
    logic [15:0]   bytes_sent;
    logic [7:0]    data;

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
        .fifo_count(fifo_count), .overflow(overflow), .tx_error(tx_error),
        .bytes_sent(bytes_sent), .data(data), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  q[$];
    bit          m_inflight, m_seen, m_wr, m_en, m_ovf, m_err;
    int          m_cyc, m_wait;
    logic [7:0]  m_data;
    logic [15:0] m_sent;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_inflight = 0; m_seen = 0; m_wr = 0; m_en = 0; m_ovf = 0; m_err = 0;
            m_cyc = 0; m_wait = 0; m_data = 8'h00; m_sent = 16'h0;
        end else begin
            int  sz;
            bit  pop;
            sz  = q.size();
            pop = !m_inflight && enable && (sz > 0) && !busy && !flush;
            // Byte in flight: one strobe cycle, one settle cycle, then the busy handshake.
            if (m_inflight) begin
                m_cyc++;
                if (m_cyc >= 2) begin
                    if (!m_seen) begin
                        if (busy) m_seen = 1;
                        else begin
                            m_wait++;
                            if (m_wait == BT) begin m_err = 1; m_inflight = 0; end
                        end
                    end else if (!busy) begin
                        m_sent++;
                        m_inflight = 0;
                    end
                end
            end
            if (pop) begin
                m_data = q.pop_front();
                m_inflight = 1; m_cyc = 0; m_wait = 0; m_seen = 0;
            end
            m_wr = pop;
            if (flush) q.delete();
            else if (wr_en) begin
                if (sz == DEPTH) m_ovf = 1;
                else q.push_back(wr_data);
            end
            m_en = enable || m_inflight;
        end
    end

    always @(negedge clk) begin
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("full",       32'(full),       32'(q.size() == DEPTH));
        chk("empty",      32'(empty),      32'(q.size() == 0));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("tx_error",   32'(tx_error),   32'(m_err));
        chk("bytes_sent", 32'(bytes_sent), 32'(m_sent));
        chk("data",       32'(data),       32'(m_data));
        chk("Tx_WR",      32'(Tx_WR),      32'(m_wr));
        chk("Tx_EN",      32'(Tx_EN),      32'(m_en));
    end

    // ---------------- transmitter emulator ----------------
    int mode = 0;   // 0: busy after dly for hi cycles, 1: dead, 2: random noise
    int dly = 2, hi = 2, t_since = 1000;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            t_since = 1000;
            busy = 1'b0;
        end else begin
            if (Tx_WR) t_since = 0;
            else if (t_since < 1000) t_since++;
            case (mode)
                0:       busy = (t_since >= dly) && (t_since < dly + hi);
                2:       busy = ($urandom % 4) == 0;
                default: busy = 1'b0;
            endcase
        end
    end

    logic [7:0] txlog[$];
    always @(negedge clk) if (reset && Tx_WR) txlog.push_back(data);

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_busy(input string nm);
        int n = 0;
        while (!busy && n < 40) begin tick(); n++; end
        chk({nm, "_busy_seen"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_data"},   32'(data),       32'h00);
        chk({nm, "_Tx_WR"},  32'(Tx_WR),      32'd0);
        chk({nm, "_Tx_EN"},  32'(Tx_EN),      32'd0);
        chk({nm, "_full"},   32'(full),       32'd0);
        chk({nm, "_empty"},  32'(empty),      32'd1);
        chk({nm, "_count"},  32'(fifo_count), 32'd0);
        chk({nm, "_ovf"},    32'(overflow),   32'd0);
        chk({nm, "_err"},    32'(tx_error),   32'd0);
        chk({nm, "_sent"},   32'(bytes_sent), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset = 1'b1;
        repeat (3) tick();
        chk_reset_vals("post_reset");

        // single byte
        enable = 1'b1;
        push(8'hAA);
        repeat (20) tick();
        chk("single_pulses", 32'(txlog.size()), 32'd1);
        if (txlog.size() > 0) chk("single_data", 32'(txlog[0]), 32'hAA);
        chk("single_sent",  32'(bytes_sent), 32'd1);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_txen",  32'(Tx_EN), 32'd1);

        // fill past full, then drain
        enable = 1'b0;
        tick();
        txlog.delete();
        for (int i = 0; i < 17; i++) push(8'(i));
        tick();
        chk("fill_count", 32'(fifo_count), 32'd16);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_ovf",   32'(overflow), 32'd1);
        enable = 1'b1;
        n = 0;
        while (bytes_sent != 16'd17 && n < 400) begin tick(); n++; end
        repeat (3) tick();
        chk("drain_sent",   32'(bytes_sent), 32'd17);
        chk("drain_pulses", 32'(txlog.size()), 32'd16);
        for (int i = 0; i < 16 && i < txlog.size(); i++) chk("drain_order", 32'(txlog[i]), 32'(i));
        chk("drain_empty", 32'(empty), 32'd1);

        // busy never rises
        mode = 1;
        txlog.delete();
        push(8'h55);
        repeat (20) tick();
        chk("tmo_err",  32'(tx_error), 32'd1);
        chk("tmo_sent", 32'(bytes_sent), 32'd17);
        chk("tmo_pulse", 32'(txlog.size()), 32'd1);
        mode = 0;
        push(8'hCC);
        repeat (20) tick();
        chk("after_tmo_sent", 32'(bytes_sent), 32'd18);
        if (txlog.size() == 2) chk("after_tmo_data", 32'(txlog[1]), 32'hCC);
        else chk("after_tmo_pulses", 32'(txlog.size()), 32'd2);

        // flush while a byte is in flight
        enable = 1'b0; hi = 4;
        push(8'h01); push(8'h02); push(8'h03);
        txlog.delete();
        enable = 1'b1;
        wait_busy("flush");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (20) tick();
        chk("flush_sent",   32'(bytes_sent), 32'd19);
        chk("flush_pulses", 32'(txlog.size()), 32'd1);
        if (txlog.size() > 0) chk("flush_data", 32'(txlog[0]), 32'h01);
        chk("flush_count",  32'(fifo_count), 32'd0);

        // async reset mid-byte
        push(8'h77);
        wait_busy("midrst");
        tick();
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        reset = 1'b1;
        enable = 1'b0; hi = 2;
        tick();

        // push coincident with pop at occupancy 5
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        chk("pp_pre_count", 32'(fifo_count), 32'd5);
        enable = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0; enable = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd5);
        chk("pp_wr",    32'(Tx_WR), 32'd1);
        chk("pp_data",  32'(data), 32'h40);
        repeat (20) tick();

        // randomized traffic
        for (int seg = 0; seg < 15; seg++) begin
            int wrp;
            mode = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
            dly  = 1 + int'($urandom % 10);
            hi   = 1 + int'($urandom % 4);
            wrp  = int'($urandom % 4);
            for (int c = 0; c < 200; c++) begin
                enable  = ($urandom % 8) != 0;
                wr_en   = int'($urandom % 4) < wrp;
                wr_data = 8'($urandom);
                flush   = ($urandom % 40) == 0;
                tick();
            end
        end
        enable = 1'b0; wr_en = 1'b0; flush = 1'b0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
